// File: rtl/fifo_arb_n.sv
// fifo_arb_n: shares one byte-stream transport FIFO pair (FWFT rx, tx) between NCH clients.
//   TX: packet-atomic round-robin arbitration. RX: demux by channel field in each header byte.
//   Optional macro ARB_TIMEOUT_EN: force-release a grant after TIMEOUT idle cycles.
// Ports:
//   CLK, RESETn            clock, async active-low reset
//   com_rden/rdempty/rddata  rx transport fifo (FWFT head)
//   com_wren/wrfull/wrdata   tx transport fifo
//   c_req/c_wren/c_wrlast/c_wrdata/c_wrfull  per-client tx side (data packed i*DW)
//   c_rden/c_rdempty/c_rddata                per-client rx side (data shared)
//   drop_cnt               headers with an unknown channel (saturating)
//   tx_timeout             sticky: a grant was force-released
module fifo_arb_n #(
    parameter int NCH = 4,
    parameter int DW = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESETn,
    output logic              com_rden,
    input  logic              com_rdempty,
    input  logic [DW-1:0]     com_rddata,
    output logic              com_wren,
    input  logic              com_wrfull,
    output logic [DW-1:0]     com_wrdata,
    input  logic [NCH-1:0]    c_req,
    input  logic [NCH-1:0]    c_wren,
    input  logic [NCH-1:0]    c_wrlast,
    input  logic [NCH*DW-1:0] c_wrdata,
    output logic [NCH-1:0]    c_wrfull,
    input  logic [NCH-1:0]    c_rden,
    output logic [NCH-1:0]    c_rdempty,
    output logic [DW-1:0]     c_rddata,
    output logic [15:0]       drop_cnt,
    output logic              tx_timeout
);
    localparam int CHW = $clog2(NCH);
    localparam int LW = DW - CHW;
    localparam int NCV = 1 << CHW;
    // Channel codes that map to a real client; the rest are discarded.
    localparam logic [NCV-1:0] CH_OK = NCV'((64'd1 << NCH) - 64'd1);

    typedef enum logic {TX_IDLE, TX_GRANT} tx_t;
    typedef enum logic [1:0] {RX_HDR, RX_BODY, RX_DROP} rx_t;

    tx_t tx_st, tx_nx;
    rx_t rx_st, rx_nx;
    logic [CHW-1:0] gnt, last, pick, idx, rx_ch, hd_ch;
    logic [LW-1:0] rx_cnt, hd_len;
    logic pick_ok, wr_acc, tx_done, tx_force, hd_ok, pop;

    // Round-robin search: lowest offset from last+1 wins.
    always_comb begin
        pick = last;
        pick_ok = 1'b0;
        idx = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(last) + k) % NCH);
            if (c_req[idx]) begin
                pick = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_st <= TX_IDLE;
            gnt <= '0;
            last <= CHW'(NCH - 1);
        end else begin
            tx_st <= tx_nx;
            if (tx_st == TX_IDLE && pick_ok) gnt <= pick;
            if (tx_st == TX_GRANT && tx_nx == TX_IDLE) last <= gnt;
        end
    end

    always_comb
        tx_nx = (tx_st == TX_IDLE) ? (pick_ok ? TX_GRANT : TX_IDLE)
                                   : ((tx_done || tx_force) ? TX_IDLE : TX_GRANT);

    always_comb begin
        wr_acc = (tx_st == TX_GRANT) & c_wren[gnt] & ~com_wrfull;
        tx_done = wr_acc & c_wrlast[gnt];
        com_wren = wr_acc;
        com_wrdata = c_wrdata[gnt*DW +: DW];
        c_wrfull = (tx_st == TX_GRANT) ? (~(NCH'(1) << gnt) | {NCH{com_wrfull}}) : '1;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Only cycles where the transport could have taken a byte count as idle.
    assign tx_force = (tx_st == TX_GRANT) & ~wr_acc & ~com_wrfull & (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            idle_cnt <= '0;
            tx_timeout <= 1'b0;
        end else begin
            idle_cnt <= (tx_st != TX_GRANT || wr_acc || tx_force) ? '0
                      : (com_wrfull ? idle_cnt : idle_cnt + TW'(1));
            if (tx_force) tx_timeout <= 1'b1;
        end
    end
`else
    assign tx_force = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    assign hd_ch = com_rddata[DW-1 -: CHW];
    assign hd_len = com_rddata[LW-1:0];
    assign hd_ok = CH_OK[hd_ch];

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_st <= RX_HDR;
            rx_ch <= '0;
            rx_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            rx_st <= rx_nx;
            if (pop && rx_st == RX_HDR) begin
                rx_ch <= hd_ch;
                rx_cnt <= hd_len;
                if (!hd_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else if (pop) begin
                rx_cnt <= rx_cnt - LW'(1);
            end
        end
    end

    always_comb begin
        rx_nx = rx_st;
        if (pop && rx_st == RX_HDR)
            rx_nx = (hd_len == '0) ? RX_HDR : (hd_ok ? RX_BODY : RX_DROP);
        else if (pop && rx_cnt == LW'(1))
            rx_nx = RX_HDR;
    end

    // A header for an unknown channel is popped by the arbiter itself.
    always_comb begin
        pop = 1'b0;
        c_rdempty = '1;
        case (rx_st)
            RX_HDR: begin
                pop = ~com_rdempty & (~hd_ok | c_rden[hd_ch]);
                c_rdempty = (~com_rdempty & hd_ok) ? ~(NCH'(1) << hd_ch) : '1;
            end
            RX_BODY: begin
                pop = ~com_rdempty & c_rden[rx_ch];
                c_rdempty = com_rdempty ? '1 : ~(NCH'(1) << rx_ch);
            end
            default: pop = ~com_rdempty;
        endcase
    end

    assign com_rden = pop;
    assign c_rddata = com_rddata;
endmodule
